rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised successor to the team's fixed 4:1, 32-bit select mux: an NCHAN-to-1 multiplexer with val/rdy handshakes.
- Arbitration is selectable: fixed-priority or round-robin.
- A single registered output stage gives 1-cycle latency and full throughput.
- Merges request streams from several producers (e.g. FFT/filter lanes) onto one shared consumer port.

Parameters:
- NBITS, 32, payload width per channel.
- NCHAN, 4, number of input channels; legal range 2..16.
- IDXW, $clog2(NCHAN), derived index width; not to be overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_val  input  NCHAN  per-channel valid; bit i belongs to channel i.
- in_rdy  output  NCHAN  per-channel ready.
- in_msg  input  NCHAN*NBITS  payloads; channel i occupies bits [i*NBITS +: NBITS].
- rr_en  input  1  1 = round-robin, 0 = fixed priority (lowest index wins).
- out_val  output  1  registered output valid.
- out_rdy  input  1  consumer ready.
- out_msg  output  NBITS  registered payload.
- out_idx  output  IDXW  registered source channel index of out_msg.

Behaviour:
- Reset: out_val=0, out_msg=0, out_idx=0, rr pointer ptr=0. in_rdy is all-zero while reset is high.
- Stage free: free = !out_val | out_rdy (combinational).
- Grant (combinational, one-hot gnt):
  - rr_en=0: lowest i with in_val[i]=1.
  - rr_en=1: first i with in_val[i]=1 searching ptr, ptr+1, …, NCHAN-1, 0, …, ptr-1 (mod NCHAN).
  - gnt is all-zero when in_val is all-zero.
- in_rdy[i] = gnt[i] & free. At most one in_rdy bit is high per cycle.
- Transfer on input i: in_val[i] & in_rdy[i]. At the next edge: out_msg = in_msg[i], out_idx = i, out_val = 1.
- If free and no transfer occurs: out_val clears to 0 at the next edge. out_msg and out_idx hold their values.
- If !free: the output register holds; all in_rdy bits are 0.
- Output transfer and new input transfer in the same cycle are legal. This gives back-to-back full throughput with no bubble.
- ptr update: only on a transfer with rr_en=1. ptr <= (i==NCHAN-1) ? 0 : i+1, wrapping at NCHAN.
  - With rr_en=0, ptr holds.
  - Toggling rr_en mid-stream takes effect in the same cycle and does not reset ptr.
- Latency: input transfer to out_val=1 is exactly 1 cycle.
- Producers must hold in_msg stable while in_val=1 and not yet accepted. The block never drops or duplicates a message.
- Asynchronous reset mid-transfer: the pending out_msg is discarded and all outputs return to reset values immediately.

Optional Feature:
- Macro: RR_ARB_MUX_LOCK_EN.
- Defined:
  - Adds ports in_last (input, NCHAN) and out_last (output, 1, registered, reset 0).
  - After a transfer with in_last[i]=0, the grant is locked to channel i. Other channels see in_rdy=0 even if channel i drops in_val.
  - Lock releases after a transfer with in_last[i]=1.
  - ptr advances only on a transfer with last=1.
  - The lock flag resets to unlocked.
- Undefined: no in_last/out_last ports; arbitration is per beat.

Test Plan:
- Reset with all in_val=1, then release → cycle 1: in_rdy=4'b0001; cycle 2: out_val=1, out_idx=0, out_msg=in_msg[0].
- rr_en=1, all four channels valid with payloads 0xA0..0xA3, out_rdy=1 → out_idx sequence 0,1,2,3,0 on consecutive cycles with no bubbles.
- rr_en=0, in_val=4'b1010 constant, out_rdy=1 → out_idx always 1; channel 3 is starved (in_rdy[3]=0 every cycle).
- out_val=1, out_rdy=0 for 3 cycles with in_val=4'b0100 → in_rdy=0; out_msg/out_idx stable; on out_rdy=1 the next edge loads channel 2.
- Assert reset mid-stream with out_val=1, ptr=2 → out_val=0, out_idx=0 immediately; first post-reset grant with rr_en=1 and all valid goes to channel 0.
- With RR_ARB_MUX_LOCK_EN, ch1 sends 3 beats (last on beat 3) while ch0 is valid → ch0 is granted only after ch1's last beat; out_last=1 only on beat 3.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: NCHAN-to-1 multiplexer with val/rdy handshakes on every port.
// Arbitration is either fixed priority (lowest index wins) or round-robin.
// A single registered output stage gives 1-cycle latency and full throughput.
// Optional packet locking is enabled by defining RR_ARB_MUX_LOCK_EN.
// When it is enabled, in_last/out_last ports are added and the grant stays
// on one channel until that channel's last beat.

module rr_arb_mux #(
    parameter int NBITS = 32,
    parameter int NCHAN = 4,
    parameter int IDXW  = $clog2(NCHAN)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NCHAN-1:0]       in_val,
    output logic [NCHAN-1:0]       in_rdy,
    input  logic [NCHAN*NBITS-1:0] in_msg,
    input  logic                   rr_en,
`ifdef RR_ARB_MUX_LOCK_EN
    input  logic [NCHAN-1:0]       in_last,
    output logic                   out_last,
`endif
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [NBITS-1:0]       out_msg,
    output logic [IDXW-1:0]        out_idx
);

    logic             outVal_q, outVal_d;
    logic [NBITS-1:0] outMsg_q, outMsg_d;
    logic [IDXW-1:0]  outIdx_q, outIdx_d;
    logic [IDXW-1:0]  ptr_q, ptr_d;

    logic             free;
    logic [NCHAN-1:0] arbGnt;
    logic [NCHAN-1:0] gnt;
    logic [IDXW-1:0]  selIdx;
    logic [IDXW:0]    scanIdx;
    logic             found;
    logic             xfer;
    logic             selLast;

`ifdef RR_ARB_MUX_LOCK_EN
    logic             lock_q, lock_d;
    logic [IDXW-1:0]  lockIdx_q, lockIdx_d;
    logic             outLast_q, outLast_d;
`endif

    // The output stage can take a new beat when it is empty or being drained
    assign free = !outVal_q || out_rdy;

    // Per-beat arbiter: scan from ptr (round-robin) or from 0 (fixed priority)
    always_comb begin
        arbGnt  = '0;
        found   = 1'b0;
        scanIdx = '0;
        for (int k = 0; k < NCHAN; k++) begin
            if (rr_en) begin
                scanIdx = {1'b0, ptr_q} + (IDXW+1)'(k);
                if (scanIdx >= (IDXW+1)'(NCHAN)) begin
                    scanIdx = scanIdx - (IDXW+1)'(NCHAN);
                end
            end else begin
                scanIdx = (IDXW+1)'(k);
            end
            if (!found && in_val[scanIdx[IDXW-1:0]]) begin
                found                      = 1'b1;
                arbGnt[scanIdx[IDXW-1:0]] = 1'b1;
            end
        end
    end

`ifdef RR_ARB_MUX_LOCK_EN
    // While a packet is open only its owner may be granted, even if it idles
    always_comb begin
        gnt = arbGnt;
        if (lock_q) begin
            gnt            = '0;
            gnt[lockIdx_q] = in_val[lockIdx_q];
        end
    end
`else
    // Without locking the arbiter result is used directly every beat
    always_comb begin
        gnt = arbGnt;
    end
`endif

    // Encode the one-hot grant into the index used to steer the payload
    always_comb begin
        selIdx = '0;
        for (int k = 0; k < NCHAN; k++) begin
            if (gnt[k]) begin
                selIdx = IDXW'(k);
            end
        end
    end

    // Ready goes only to the granted channel, and never while reset is held
    assign in_rdy = gnt & {NCHAN{free && !reset}};
    assign xfer   = |in_rdy;

`ifdef RR_ARB_MUX_LOCK_EN
    assign selLast = in_last[selIdx];
`else
    assign selLast = 1'b1;
`endif

    // Next state of the output register: load on transfer, empty when drained
    always_comb begin
        outVal_d = outVal_q;
        outMsg_d = outMsg_q;
        outIdx_d = outIdx_q;
        if (xfer) begin
            outVal_d = 1'b1;
            outMsg_d = in_msg[selIdx*NBITS +: NBITS];
            outIdx_d = selIdx;
        end else if (free) begin
            outVal_d = 1'b0;
        end
    end

    // Round-robin pointer moves past the winner only at the end of a packet
    always_comb begin
        ptr_d = ptr_q;
        if (xfer && rr_en && selLast) begin
            ptr_d = (selIdx == IDXW'(NCHAN-1)) ? '0 : selIdx + IDXW'(1);
        end
    end

`ifdef RR_ARB_MUX_LOCK_EN
    // Open the lock on a non-last beat, release it on the last one
    always_comb begin
        lock_d    = lock_q;
        lockIdx_d = lockIdx_q;
        outLast_d = outLast_q;
        if (xfer) begin
            lock_d    = !selLast;
            lockIdx_d = selIdx;
            outLast_d = selLast;
        end
    end

    // Lock state and registered last flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_q    <= 1'b0;
            lockIdx_q <= '0;
            outLast_q <= 1'b0;
        end else begin
            lock_q    <= lock_d;
            lockIdx_q <= lockIdx_d;
            outLast_q <= outLast_d;
        end
    end

    assign out_last = outLast_q;
`endif

    // Output stage and arbitration pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outVal_q <= 1'b0;
            outMsg_q <= '0;
            outIdx_q <= '0;
            ptr_q    <= '0;
        end else begin
            outVal_q <= outVal_d;
            outMsg_q <= outMsg_d;
            outIdx_q <= outIdx_d;
            ptr_q    <= ptr_d;
        end
    end

    assign out_val = outVal_q;
    assign out_msg = outMsg_q;
    assign out_idx = outIdx_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed test of rr_arb_mux with a scoreboard.
// The stimulus pushes the expected output beats into a queue.
// A separate monitor pops the queue and compares on each output handshake.
// Define RR_ARB_MUX_LOCK_EN to build and exercise the packet-lock variant.

module tb_rr_arb_mux;

    localparam int NBITS = 32;
    localparam int NCHAN = 4;
    localparam int IDXW  = 2;

    typedef struct {
        logic [IDXW-1:0]  idx;
        logic [NBITS-1:0] msg;
        logic             last;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [NCHAN-1:0]       inVal;
    logic [NCHAN-1:0]       inRdy;
    logic [NCHAN*NBITS-1:0] inMsg;
    logic                   rrEn;
    logic                   outVal;
    logic                   outRdy;
    logic [NBITS-1:0]       outMsg;
    logic [IDXW-1:0]        outIdx;
    logic [NCHAN-1:0]       inLast;
    logic                   outLast;

    beat_t sbQueue[$];
    int    checks = 0;
    int    errors = 0;

    rr_arb_mux #(.NBITS(NBITS), .NCHAN(NCHAN)) dut (
        .clk     (clk),
        .reset   (reset),
        .in_val  (inVal),
        .in_rdy  (inRdy),
        .in_msg  (inMsg),
        .rr_en   (rrEn),
`ifdef RR_ARB_MUX_LOCK_EN
        .in_last (inLast),
        .out_last(outLast),
`endif
        .out_val (outVal),
        .out_rdy (outRdy),
        .out_msg (outMsg),
        .out_idx (outIdx)
    );

`ifndef RR_ARB_MUX_LOCK_EN
    assign outLast = 1'b1;
`endif

    // Free-running clock, period 10
    always #5 clk = ~clk;

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive the handshake inputs that change from vector to vector
    task automatic applyStimulus(input logic [NCHAN-1:0] val, input logic rr, input logic ordy);
        inVal  = val;
        rrEn   = rr;
        outRdy = ordy;
    endtask

    task automatic pushBeat(input int idx, input logic [NBITS-1:0] msg, input logic last);
        beat_t b;
        b.idx  = IDXW'(idx);
        b.msg  = msg;
        b.last = last;
        sbQueue.push_back(b);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Let all pending beats leave, with a bounded wait, then idle the stage
    task automatic drain();
        applyStimulus('0, rrEn, 1'b1);
        for (int c = 0; c < 20 && sbQueue.size() != 0; c++) @(negedge clk);
        checkOutput("drainEmpty", 64'(sbQueue.size()), 64'd0);
        sbQueue.delete();
        nextCycle();
        nextCycle();
    endtask

    // Monitor: every output handshake must match the oldest expected beat
    always @(negedge clk) begin
        if (!reset && outVal && outRdy) begin
            if (sbQueue.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedBeat: got idx %0d msg 0x%0h, expected none", outIdx, outMsg);
            end else begin
                beat_t b;
                b = sbQueue.pop_front();
                checkOutput("sbIdx", 64'(outIdx), 64'(b.idx));
                checkOutput("sbMsg", 64'(outMsg), 64'(b.msg));
`ifdef RR_ARB_MUX_LOCK_EN
                checkOutput("sbLast", 64'(outLast), 64'(b.last));
`endif
            end
        end
    end

    initial begin
        int seq[5];
        seq = '{0, 1, 2, 3, 0};
        reset  = 1'b1;
        inLast = '1;
        for (int i = 0; i < NCHAN; i++) inMsg[i*NBITS +: NBITS] = 32'hA0 + 32'(i);
        applyStimulus(4'b1111, 1'b0, 1'b1);

        // Reset held with every channel valid: no ready, outputs cleared
        nextCycle();
        @(negedge clk);
        checkOutput("resetInRdy", 64'(inRdy), 64'd0);
        checkOutput("resetOutVal", 64'(outVal), 64'd0);
        checkOutput("resetOutMsg", 64'(outMsg), 64'd0);
        checkOutput("resetOutIdx", 64'(outIdx), 64'd0);

        // Release: channel 0 wins under fixed priority, appears one cycle later
        nextCycle();
        reset = 1'b0;
        pushBeat(0, 32'hA0, 1'b1);
        @(negedge clk);
        checkOutput("relInRdy", 64'(inRdy), 64'b0001);
        nextCycle();
        applyStimulus('0, 1'b0, 1'b1);
        checkOutput("relLatency", 64'(outVal), 64'd1);
        drain();

        // Round-robin with all valid: 0,1,2,3,0 back to back
        applyStimulus(4'b1111, 1'b1, 1'b1);
        for (int c = 0; c < 5; c++) begin
            pushBeat(seq[c], 32'hA0 + 32'(seq[c]), 1'b1);
            @(negedge clk);
            checkOutput("rrInRdy", 64'(inRdy), 64'(4'b0001 << seq[c]));
            if (c > 0) checkOutput("rrNoBubble", 64'(outVal), 64'd1);
            nextCycle();
        end
        drain();

        // Fixed priority with 1010: channel 1 always, channel 3 starved
        applyStimulus(4'b1010, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            pushBeat(1, 32'hA1, 1'b1);
            @(negedge clk);
            checkOutput("fixInRdy", 64'(inRdy), 64'b0010);
            nextCycle();
        end
        drain();

        // Backpressure: the stage holds while out_rdy is low
        applyStimulus(4'b0100, 1'b0, 1'b0);
        pushBeat(2, 32'hA2, 1'b1);
        @(negedge clk);
        checkOutput("bpFirstRdy", 64'(inRdy), 64'b0100);
        nextCycle();
        inMsg[2*NBITS +: NBITS] = 32'hB2;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("bpInRdy", 64'(inRdy), 64'd0);
            checkOutput("bpOutVal", 64'(outVal), 64'd1);
            checkOutput("bpOutIdx", 64'(outIdx), 64'd2);
            checkOutput("bpOutMsg", 64'(outMsg), 64'hA2);
            nextCycle();
        end
        pushBeat(2, 32'hB2, 1'b1);
        applyStimulus(4'b0100, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("bpReleaseRdy", 64'(inRdy), 64'b0100);
        nextCycle();
        drain();
        inMsg[2*NBITS +: NBITS] = 32'hA2;

        // Move ptr to 2 with a single ch1 beat, then reset while it is pending
        applyStimulus(4'b0010, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("ptrSetRdy", 64'(inRdy), 64'b0010);
        nextCycle();
        applyStimulus(4'b1111, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("pendOutVal", 64'(outVal), 64'd1);
        checkOutput("pendOutIdx", 64'(outIdx), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("asyncOutVal", 64'(outVal), 64'd0);
        checkOutput("asyncOutIdx", 64'(outIdx), 64'd0);
        checkOutput("asyncOutMsg", 64'(outMsg), 64'd0);
        checkOutput("asyncInRdy", 64'(inRdy), 64'd0);
        nextCycle();
        reset = 1'b0;
        applyStimulus(4'b1111, 1'b1, 1'b1);
        pushBeat(0, 32'hA0, 1'b1);
        @(negedge clk);
        checkOutput("postRstRdy", 64'(inRdy), 64'b0001);
        nextCycle();
        drain();

`ifdef RR_ARB_MUX_LOCK_EN
        // Three-beat packet on ch1 holds off ch0 until its last beat
        inLast = '0;
        inMsg[1*NBITS +: NBITS] = 32'hC1;
        applyStimulus(4'b0010, 1'b0, 1'b1);
        pushBeat(1, 32'hC1, 1'b0);
        @(negedge clk);
        checkOutput("lockBeat1", 64'(inRdy), 64'b0010);
        nextCycle();
        inMsg[1*NBITS +: NBITS] = 32'hC2;
        applyStimulus(4'b0011, 1'b0, 1'b1);
        pushBeat(1, 32'hC2, 1'b0);
        @(negedge clk);
        checkOutput("lockBeat2", 64'(inRdy), 64'b0010);
        nextCycle();
        inMsg[1*NBITS +: NBITS] = 32'hC3;
        inLast = 4'b0010;
        pushBeat(1, 32'hC3, 1'b1);
        @(negedge clk);
        checkOutput("lockBeat3", 64'(inRdy), 64'b0010);
        nextCycle();
        inLast = 4'b0001;
        applyStimulus(4'b0001, 1'b0, 1'b1);
        pushBeat(0, 32'hA0, 1'b1);
        @(negedge clk);
        checkOutput("lockRelease", 64'(inRdy), 64'b0001);
        nextCycle();
        drain();
        inLast = '1;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
